// File: rtl/rv_pipe_ctrl.sv
// Hazard/stall controller for the 5-stage core: tracks rd state for Q102H..Q104H,
// drives stage readies, bubbles, flush and EX forwarding. `RV_FWD_EN enables forwarding.
module rv_pipe_ctrl #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid_Q101H,
    input  logic [4:0]             i_rs1_Q101H,
    input  logic [4:0]             i_rs2_Q101H,
    input  logic                   i_use_rs1_Q101H,
    input  logic                   i_use_rs2_Q101H,
    input  logic [4:0]             i_rd_Q101H,
    input  logic                   i_reg_write_Q101H,
    input  logic                   i_is_load_Q101H,
    input  logic                   i_is_mem_Q101H,
    input  logic                   i_branch_taken_Q102H,
    input  logic                   i_dmem_ready_Q103H,
    output logic                   o_ready_Q101H,
    output logic                   o_ready_Q102H,
    output logic                   o_ready_Q103H,
    output logic                   o_ready_Q104H,
    output logic                   o_flush_Q101H,
    output logic                   o_valid_Q102H,
    output logic                   o_valid_Q103H,
    output logic                   o_valid_Q104H,
    output logic [1:0]             o_fwd_sel1_Q102H,
    output logic [1:0]             o_fwd_sel2_Q102H,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    logic                   r_valid_q2, r_rw_q2, r_ld_q2, r_mem_q2, r_use1_q2, r_use2_q2;
    logic [4:0]             r_rd_q2, r_rs1_q2, r_rs2_q2;
    logic                   r_valid_q3, r_rw_q3, r_ld_q3, r_mem_q3;
    logic [4:0]             r_rd_q3;
    logic                   r_valid_q4, r_rw_q4, r_ld_q4, r_mem_q4;
    logic [4:0]             r_rd_q4;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic       w_ms, w_flush, w_hz_raw, w_hz;
    logic [1:0] w_fwd1, w_fwd2;
    logic       w_unused;

    function automatic logic f_match(input logic p_v, input logic p_rw, input logic [4:0] p_rd,
                                     input logic [4:0] rs, input logic use_rs);
        return p_v & p_rw & (p_rd != 5'd0) & (p_rd == rs) & use_rs;
    endfunction

    assign w_ms    = r_valid_q3 & r_mem_q3 & ~i_dmem_ready_Q103H;
    assign w_flush = i_branch_taken_Q102H & r_valid_q2 & ~w_ms;
    assign w_hz    = w_hz_raw & ~w_ms & ~w_flush;

`ifdef RV_FWD_EN
    // Only a load still in Q102H cannot be forwarded in time.
    assign w_hz_raw = i_valid_Q101H & r_ld_q2 &
                      (f_match(r_valid_q2, r_rw_q2, r_rd_q2, i_rs1_Q101H, i_use_rs1_Q101H) |
                       f_match(r_valid_q2, r_rw_q2, r_rd_q2, i_rs2_Q101H, i_use_rs2_Q101H));

    // Youngest producer wins: Q103H result before Q104H write-back data.
    always_comb begin
        w_fwd1 = 2'b00;
        w_fwd2 = 2'b00;
        if (f_match(r_valid_q3, r_rw_q3, r_rd_q3, r_rs1_q2, r_use1_q2)) begin
            w_fwd1 = 2'b01;
        end else if (f_match(r_valid_q4, r_rw_q4, r_rd_q4, r_rs1_q2, r_use1_q2)) begin
            w_fwd1 = 2'b10;
        end else begin
            w_fwd1 = 2'b00;
        end
        if (f_match(r_valid_q3, r_rw_q3, r_rd_q3, r_rs2_q2, r_use2_q2)) begin
            w_fwd2 = 2'b01;
        end else if (f_match(r_valid_q4, r_rw_q4, r_rd_q4, r_rs2_q2, r_use2_q2)) begin
            w_fwd2 = 2'b10;
        end else begin
            w_fwd2 = 2'b00;
        end
    end
`else
    // Without forwarding the consumer waits until the producer reaches Q104H.
    assign w_hz_raw = i_valid_Q101H &
                      (f_match(r_valid_q2, r_rw_q2, r_rd_q2, i_rs1_Q101H, i_use_rs1_Q101H) |
                       f_match(r_valid_q2, r_rw_q2, r_rd_q2, i_rs2_Q101H, i_use_rs2_Q101H) |
                       f_match(r_valid_q3, r_rw_q3, r_rd_q3, i_rs1_Q101H, i_use_rs1_Q101H) |
                       f_match(r_valid_q3, r_rw_q3, r_rd_q3, i_rs2_Q101H, i_use_rs2_Q101H));
    assign w_fwd1 = 2'b00;
    assign w_fwd2 = 2'b00;
`endif

    assign w_unused = ^{r_ld_q3, r_ld_q4, r_mem_q4, r_rd_q4, r_rw_q4,
                        r_rs1_q2, r_rs2_q2, r_use1_q2, r_use2_q2};

    // Stage enables and fetch flush, prioritised memory stall > flush > hazard.
    always_comb begin
        o_ready_Q101H = 1'b0;
        o_ready_Q102H = 1'b0;
        o_ready_Q103H = 1'b0;
        o_ready_Q104H = 1'b0;
        o_flush_Q101H = 1'b0;
        if (i_rst) begin
            o_ready_Q101H = 1'b0;
        end else if (w_ms) begin
            o_ready_Q104H = 1'b1;
        end else if (w_flush) begin
            o_flush_Q101H = 1'b1;
            o_ready_Q101H = 1'b1;
            o_ready_Q102H = 1'b1;
            o_ready_Q103H = 1'b1;
            o_ready_Q104H = 1'b1;
        end else if (w_hz) begin
            o_ready_Q102H = 1'b1;
            o_ready_Q103H = 1'b1;
            o_ready_Q104H = 1'b1;
        end else begin
            o_ready_Q101H = 1'b1;
            o_ready_Q102H = 1'b1;
            o_ready_Q103H = 1'b1;
            o_ready_Q104H = 1'b1;
        end
    end

    // Per-stage state shift, bubble insertion and stall counting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            {r_valid_q2, r_rw_q2, r_ld_q2, r_mem_q2, r_use1_q2, r_use2_q2} <= 6'd0;
            {r_rd_q2, r_rs1_q2, r_rs2_q2} <= 15'd0;
            {r_valid_q3, r_rw_q3, r_ld_q3, r_mem_q3, r_rd_q3} <= 9'd0;
            {r_valid_q4, r_rw_q4, r_ld_q4, r_mem_q4, r_rd_q4} <= 9'd0;
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else begin
            if (o_ready_Q102H) begin
                r_valid_q2 <= i_valid_Q101H & ~w_flush & ~w_hz;
                r_rd_q2    <= i_rd_Q101H;
                r_rw_q2    <= i_reg_write_Q101H;
                r_ld_q2    <= i_is_load_Q101H;
                r_mem_q2   <= i_is_mem_Q101H;
                r_rs1_q2   <= i_rs1_Q101H;
                r_rs2_q2   <= i_rs2_Q101H;
                r_use1_q2  <= i_use_rs1_Q101H;
                r_use2_q2  <= i_use_rs2_Q101H;
            end
            if (o_ready_Q103H) begin
                {r_valid_q3, r_rw_q3, r_ld_q3, r_mem_q3, r_rd_q3} <=
                    {r_valid_q2, r_rw_q2, r_ld_q2, r_mem_q2, r_rd_q2};
            end
            if (o_ready_Q104H) begin
                r_valid_q4 <= r_valid_q3 & ~w_ms;
                {r_rw_q4, r_ld_q4, r_mem_q4, r_rd_q4} <= {r_rw_q3, r_ld_q3, r_mem_q3, r_rd_q3};
            end
            if (w_hz) begin
                r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_valid_Q102H    = r_valid_q2;
    assign o_valid_Q103H    = r_valid_q3;
    assign o_valid_Q104H    = r_valid_q4;
    assign o_fwd_sel1_Q102H = w_fwd1;
    assign o_fwd_sel2_Q102H = w_fwd2;
    assign o_stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Bench for rv_pipe_ctrl: directed scenarios plus random instruction streams checked
// against a stage-array reference model; follows `RV_FWD_EN like the design.
module tb_rv_pipe_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw, ld, mem;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
    } ins_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, br, dmem;
    ins_t cur;
    logic o_r1, o_r2, o_r3, o_r4, o_flush, o_v2, o_v3, o_v4;
    logic [1:0] o_f1, o_f2;
    logic [31:0] o_cnt;

    rv_pipe_ctrl #(.STALL_CNT_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid_Q101H(cur.v),
        .i_rs1_Q101H(cur.rs1), .i_rs2_Q101H(cur.rs2),
        .i_use_rs1_Q101H(cur.u1), .i_use_rs2_Q101H(cur.u2),
        .i_rd_Q101H(cur.rd), .i_reg_write_Q101H(cur.rw),
        .i_is_load_Q101H(cur.ld), .i_is_mem_Q101H(cur.mem),
        .i_branch_taken_Q102H(br), .i_dmem_ready_Q103H(dmem),
        .o_ready_Q101H(o_r1), .o_ready_Q102H(o_r2), .o_ready_Q103H(o_r3), .o_ready_Q104H(o_r4),
        .o_flush_Q101H(o_flush),
        .o_valid_Q102H(o_v2), .o_valid_Q103H(o_v3), .o_valid_Q104H(o_v4),
        .o_fwd_sel1_Q102H(o_f1), .o_fwd_sel2_Q102H(o_f2),
        .o_stall_cnt(o_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    ins_t pipe2, pipe3, pipe4;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hits(input ins_t p, input logic [4:0] rs, input logic u);
        return p.v && p.rw && (p.rd != 5'd0) && (p.rd == rs) && u;
    endfunction

    function automatic bit reads_from(input ins_t p, input ins_t c);
        return hits(p, c.rs1, c.u1) || hits(p, c.rs2, c.u2);
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input logic u);
`ifdef RV_FWD_EN
        if (hits(pipe3, rs, u)) return 2'b01;
        if (hits(pipe4, rs, u)) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic ins_t mk(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                                input logic mem, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
        ins_t i;
        i.v = v; i.rd = rd; i.rw = rw; i.ld = ld; i.mem = mem;
        i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
        return i;
    endfunction

    // One clock: compare every output against the model, then advance the model.
    task automatic cycle(output bit accepted);
        bit ms, fl, hz;
        logic [3:0] er;
        #1;
        if (rst) begin
            pipe2 = '0; pipe3 = '0; pipe4 = '0; m_cnt = 32'd0;
        end
        ms = pipe3.v && pipe3.mem && !dmem;
        fl = br && pipe2.v && !ms;
`ifdef RV_FWD_EN
        hz = cur.v && pipe2.ld && reads_from(pipe2, cur);
`else
        hz = cur.v && (reads_from(pipe2, cur) || reads_from(pipe3, cur));
`endif
        hz = hz && !ms && !fl;
        er = rst ? 4'b0000 : ms ? 4'b1000 : hz ? 4'b1110 : 4'b1111;
        chk("ready", 32'({o_r4, o_r3, o_r2, o_r1}), 32'(er));
        chk("flush", 32'(o_flush), 32'(!rst && fl));
        chk("valid2", 32'(o_v2), 32'(pipe2.v));
        chk("valid3", 32'(o_v3), 32'(pipe3.v));
        chk("valid4", 32'(o_v4), 32'(pipe4.v));
        chk("fwd1", 32'(o_f1), 32'(exp_fwd(pipe2.rs1, pipe2.u1)));
        chk("fwd2", 32'(o_f2), 32'(exp_fwd(pipe2.rs2, pipe2.u2)));
        chk("stall_cnt", o_cnt, m_cnt);
        accepted = er[0];
        @(posedge clk);
        if (!rst) begin
            if (ms) begin
                pipe4.v = 1'b0;
            end else begin
                pipe4 = pipe3;
                pipe3 = pipe2;
                pipe2 = cur;
                if (fl || hz) pipe2.v = 1'b0;
                if (hz) m_cnt = m_cnt + 32'd1;
            end
        end
        @(negedge clk);
    endtask

    // Present an instruction until decode accepts it; returns stall cycles taken.
    task automatic issue(input ins_t i, output int stalls);
        bit acc;
        acc = 1'b0;
        cur = i;
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(acc);
            if (acc) break;
            stalls++;
        end
        chk("issue_bound", 32'(acc), 32'd1);
    endtask

    initial begin
        int st;
        bit acc;
        logic [31:0] c0;
        ins_t nop;
        nop = '0;
        pipe2 = '0; pipe3 = '0; pipe4 = '0; m_cnt = 32'd0;
        rst = 1'b1; br = 1'b0; dmem = 1'b1; cur = nop;
        @(negedge clk);
        cycle(acc);
        cycle(acc);
        rst = 1'b0;
        cycle(acc);
        chk("release_ready", 32'(acc), 32'd1);

`ifdef RV_FWD_EN
        issue(mk(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0), st);
        issue(mk(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1), st);
        chk("lu_stalls", 32'(st), 32'd1);
        chk("lu_cnt", o_cnt, 32'd1);
        #1 chk("lu_fwd1", 32'(o_f1), 32'd2);
        issue(mk(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1), st);
        issue(mk(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1), st);
        chk("raw_stalls", 32'(st), 32'd0);
        #1 chk("raw_fwd1", 32'(o_f1), 32'd1);
        chk("raw_fwd2", 32'(o_f2), 32'd1);
        issue(mk(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1), st);
        issue(mk(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1), st);
        issue(mk(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 5'd1, 1'b1), st);
        #1 chk("two_back_fwd1", 32'(o_f1), 32'd2);
        issue(mk(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0), st);
        issue(mk(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1), st);
        #1 chk("x0_fwd1", 32'(o_f1), 32'd0);
`else
        issue(mk(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1), st);
        issue(mk(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 5'd2, 1'b1), st);
        chk("raw_stalls", 32'(st), 32'd2);
        chk("raw_cnt", o_cnt, 32'd2);
        #1 chk("raw_fwd1", 32'(o_f1), 32'd0);
`endif

        // Taken branch in Q102H while a load-use consumer waits in Q101H.
        issue(mk(1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0), st);
        c0 = m_cnt;
        cur = mk(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1);
        br = 1'b1;
        #1 chk("br_flush", 32'(o_flush), 32'd1);
        cycle(acc);
        br = 1'b0;
        chk("br_acc", 32'(acc), 32'd1);
        chk("br_cnt", o_cnt, c0);
        chk("br_kill", 32'(o_v2), 32'd0);

        // Store stalled in Q103H for three cycles while a branch is taken.
        issue(mk(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1), st);
        issue(mk(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), st);
        cur = mk(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);
        dmem = 1'b0; br = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(acc);
            chk("ms_hold", 32'(acc), 32'd0);
            chk("ms_v4", 32'(o_v4), 32'd0);
        end
        dmem = 1'b1;
        #1 chk("ms_flush_after", 32'(o_flush), 32'd1);
        cycle(acc);
        br = 1'b0;

        // Randomized instruction stream with stalls, flushes and memory waits.
        acc = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if (acc) begin
                cur.v   = ($urandom_range(0, 4) != 0);
                cur.ld  = ($urandom_range(0, 3) == 0);
                cur.mem = cur.ld | ($urandom_range(0, 5) == 0);
                cur.rw  = cur.ld | 1'($urandom_range(0, 1));
                cur.rd  = 5'($urandom_range(0, 3));
                cur.rs1 = 5'($urandom_range(0, 3));
                cur.rs2 = 5'($urandom_range(0, 3));
                cur.u1  = 1'($urandom_range(0, 1));
                cur.u2  = 1'($urandom_range(0, 1));
            end
            br   = ($urandom_range(0, 9) == 0);
            dmem = ($urandom_range(0, 3) != 0);
            cycle(acc);
        end
        br = 1'b0; dmem = 1'b1;

        // Reset asserted in the middle of a load-use stall.
        issue(mk(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0), st);
        cur = mk(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1);
        cycle(acc);
        chk("pre_rst_stall", 32'(acc), 32'd0);
        rst = 1'b1;
        cycle(acc);
        chk("rst_cnt", o_cnt, 32'd0);
        rst = 1'b0;
        cycle(acc);
        chk("rst_nostall", 32'(acc), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
